// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: key indices, matrix codes and FSM states.
package keypad_pkg;

  localparam int NUM_KEYS = 12;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_4    = 4'd3;
  localparam logic [3:0] KEY_5    = 4'd4;
  localparam logic [3:0] KEY_6    = 4'd5;
  localparam logic [3:0] KEY_7    = 4'd6;
  localparam logic [3:0] KEY_8    = 4'd7;
  localparam logic [3:0] KEY_9    = 4'd8;
  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_0    = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // The '*', '0', '#' row is strobed last, so it carries the 1000 code.
  function automatic logic [3:0] key_row(input logic [3:0] k);
    logic [3:0] r;
    if (k < 4'd3)      r = 4'b0100;
    else if (k < 4'd6) r = 4'b0010;
    else if (k < 4'd9) r = 4'b0001;
    else               r = 4'b1000;
    return r;
  endfunction

  function automatic logic [2:0] key_col(input logic [3:0] k);
    logic [2:0] c;
    case (k)
      4'd0, 4'd3, 4'd6, 4'd9:  c = 3'b100;
      4'd1, 4'd4, 4'd7, 4'd10: c = 3'b010;
      default:                 c = 3'b001;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Brings the scanner row strobe into clk and flags the start of each scan (entry to row 1000).
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic       scan_start_o
);

  logic [3:0] row_m_q;
  logic [3:0] row_s_q;
  logic [3:0] row_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m_q <= '0;
      row_s_q <= '0;
      row_q   <= '0;
    end else begin
      row_m_q <= row_i;
      row_s_q <= row_m_q;
      row_q   <= row_s_q;
    end
  end

  // Exact compare, so zero or multi-hot strobes never look like a scan start.
  assign scan_start_o = (row_s_q == 4'b1000) && (row_q != 4'b1000);

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one 4x3 keypad press per command for a row-strobing scanner, timed in whole scans.
// Build option KEYPAD_EMU_BOUNCE_EN adds LFSR contact chatter after each press/release edge.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS    = 4,
  parameter int GAP_SCANS     = 2,
  parameter int SCAN_TIMEOUT  = 1048576,
  parameter int BOUNCE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_idx,
  output logic       key_ready,
  input  logic [3:0] row_i,
  output logic [2:0] col_o,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int HW = $clog2(HOLD_SCANS) + 1;
  localparam int GW = $clog2(GAP_SCANS) + 1;
  localparam int TW = $clog2(SCAN_TIMEOUT) + 1;
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_SCANS);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_SCANS);
  localparam logic [TW-1:0] TMO_END  = TW'(SCAN_TIMEOUT - 1);

  if (HOLD_SCANS < 1 || GAP_SCANS < 1 || SCAN_TIMEOUT < 16 || BOUNCE_CYCLES < 1) begin : g_param_check
    $error("keypad_emulator: parameter out of range");
  end

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          pressed_q, pressed_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [GW-1:0] gap_q, gap_d, gap_inc;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmo_hit;
  logic          scan_start;
  logic          pressed_eff;

  keypad_row_sync u_row_sync (
    .clk          (clk),
    .rst          (rst),
    .row_i        (row_i),
    .scan_start_o (scan_start)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pressed_q <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pressed_q <= pressed_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pressed_d = pressed_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    hold_inc  = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    gap_inc   = (gap_q == '1) ? gap_q : gap_q + 1'b1;
    tmo_hit   = (state_q != ST_IDLE) && (tmo_q == TMO_END);

    if (state_q != ST_IDLE) begin
      if (scan_start)            tmo_d = '0;
      else if (tmo_q != TMO_END) tmo_d = tmo_q + 1'b1;
    end

    // A stalled scanner aborts the press; this outranks GAP completion.
    if (tmo_hit) begin
      pressed_d = 1'b0;
      err_d     = 1'b1;
      tmo_d     = '0;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            if (key_idx < 4'(NUM_KEYS)) begin
              idx_d   = key_idx;
              tmo_d   = '0;
              state_d = ST_ARM;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (scan_start) begin
            pressed_d = 1'b1;
            hold_d    = '0;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (scan_start) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_END) begin
              pressed_d = 1'b0;
              gap_d     = '0;
              state_d   = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (scan_start) begin
            gap_d = gap_inc;
            if (gap_inc == GAP_END) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYCLES) + 1;

  logic [7:0]    lfsr_q;
  logic [BW-1:0] bounce_q;
  logic          edge_enter;

  assign edge_enter = ((state_d == ST_HOLD) && (state_q != ST_HOLD)) ||
                      ((state_d == ST_GAP)  && (state_q != ST_GAP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q   <= 8'hA5;
      bounce_q <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (edge_enter)         bounce_q <= BW'(BOUNCE_CYCLES);
      else if (bounce_q != 0) bounce_q <= bounce_q - 1'b1;
    end
  end

  assign pressed_eff = (bounce_q != '0) ? lfsr_q[0] : pressed_q;
`else
  assign pressed_eff = pressed_q;
`endif

  // Passive switch: the column follows the raw strobe with no clocked delay.
  always_comb begin
    col_o = 3'b000;
    if (pressed_eff && (row_i == key_row(idx_q))) col_o = key_col(idx_q);
  end

  assign key_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Drives keypad_emulator with a scanner model and checks it against a scan-level reference model.
module tb_keypad_emulator;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int T  = 100;
  localparam int PH = 6;

  logic       clk, rst, key_valid, key_ready, busy, done, err;
  logic [3:0] key_idx, row_i;
  logic [2:0] col_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;

  logic [3:0]  rtab [4];
  logic [2:0]  ctab [3];
  logic [3:0]  junk_pat [5];
  logic [11:0] scan_seen;

  bit m_active;
  int m_nstart, m_key, exp_done, exp_err, m_accepts;

  keypad_emulator #(
    .HOLD_SCANS    (H),
    .GAP_SCANS     (G),
    .SCAN_TIMEOUT  (T),
    .BOUNCE_CYCLES (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_idx   (key_idx),
    .key_ready (key_ready),
    .row_i     (row_i),
    .col_o     (col_o),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_seen <= 1'b1;
    end
  end

  // Reference model: a key is down for scans 1..H after the first scan start following acceptance,
  // and the command completes on scan start H+G+1.
  function automatic bit m_pressed();
    return m_active && (m_nstart >= 1) && (m_nstart <= H);
  endfunction

  task automatic m_start();
    if (m_active) begin
      m_nstart++;
      if (m_nstart == H + G + 1) begin
        m_active = 1'b0;
        exp_done++;
      end
    end
  endtask

  task automatic m_try_accept();
    if (!m_active && key_valid) begin
      if (key_idx < 4'd12) begin
        m_active = 1'b1;
        m_nstart = 0;
        m_key    = int'(key_idx);
        m_accepts++;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic do_phase(input logic [3:0] r);
    logic [2:0] exp_col;
    row_i = r;
    m_try_accept();
    if (r == 4'b1000) begin
      m_start();
      m_try_accept();
    end
    repeat (PH) @(negedge clk);
    exp_col = 3'b000;
    if (m_pressed() && (r == rtab[m_key / 3])) exp_col = ctab[m_key % 3];
    checks++;
    if (col_o !== exp_col) begin
      errors++;
      $display("FAIL col row=%b got %b want %b", r, col_o, exp_col);
    end
    checks++;
    if (key_ready !== (m_active ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL key_ready got %b want %b", key_ready, !m_active);
    end
    checks++;
    if (busy !== (m_active ? 1'b1 : 1'b0)) begin
      errors++;
      $display("FAIL busy got %b want %b", busy, m_active);
    end
    for (int k = 0; k < 12; k++)
      if (col_o != 3'b000 && rtab[k / 3] == r && ctab[k % 3] == col_o) scan_seen[k] = 1'b1;
  endtask

  task automatic run_scan(input bit junk);
    scan_seen = '0;
    do_phase(4'b0100);
    do_phase(4'b0010);
    if (junk) do_phase(junk_pat[$urandom_range(0, 4)]);
    do_phase(4'b0001);
    do_phase(4'b1000);
    checks++;
    if (done_cnt !== exp_done) begin
      errors++;
      $display("FAIL done_count got %0d want %0d", done_cnt, exp_done);
    end
    checks++;
    if (err_cnt !== exp_err) begin
      errors++;
      $display("FAIL err_count got %0d want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic send_cmd(input logic [3:0] idx);
    key_idx   = idx;
    key_valid = 1'b1;
    checks++;
    if (key_ready !== (m_active ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL send_ready got %b want %b", key_ready, !m_active);
    end
    m_try_accept();
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_valid = 1'b0;
    key_idx = '0;
    row_i = '0;
    #2;
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", key_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got done=%b err=%b want 0 0", done, err);
    end
    for (int i = 0; i < 4; i++) begin
      row_i = rtab[i];
      #1;
      checks++;
      if (col_o !== 3'b000) begin errors++; $display("FAIL reset_col got %b want 000", col_o); end
    end
    row_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [11:0] exp_seen;
    int d0, hits;
    d0 = done_cnt;
    hits = 0;
    send_cmd(4'd4);
    for (int s = 0; s < H + G + 2; s++) begin
      exp_seen = m_pressed() ? 12'h010 : 12'h000;
      run_scan(1'b0);
      if (scan_seen != 12'h000) hits++;
      checks++;
      if (scan_seen !== exp_seen) begin
        errors++;
        $display("FAIL loopback_scan%0d got %h want %h", s, scan_seen, exp_seen);
      end
    end
    checks++;
    if (hits !== H) begin errors++; $display("FAIL loopback_hold_scans got %0d want %0d", hits, H); end
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL loopback_done got %0d want %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_star_hash();
    int e0, d0;
    row_i = 4'b0000;
    repeat (3) @(negedge clk);
    send_cmd(4'd11);
    e0 = err_cnt;
    d0 = done_cnt;
    row_i = 4'b1000;
    m_start();
    repeat (5) @(negedge clk);
    checks++;
    if (col_o !== 3'b001) begin errors++; $display("FAIL hash_row1000 got %b want 001", col_o); end
    row_i = 4'b0100;
    #1;
    checks++;
    if (col_o !== 3'b000) begin errors++; $display("FAIL hash_row0100 got %b want 000", col_o); end
    repeat (T + 10) @(negedge clk);
    m_active = 1'b0;
    exp_err++;
    checks++;
    if (err_cnt !== e0 + 1) begin errors++; $display("FAIL hash_timeout_err got %0d want %0d", err_cnt - e0, 1); end
    checks++;
    if (busy !== 1'b0 || done_cnt !== d0) begin
      errors++;
      $display("FAIL hash_timeout_state got busy=%b dones=%0d want 0 0", busy, done_cnt - d0);
    end
  endtask

  task automatic test_bad_idx();
    int e0;
    logic [3:0] bad;
    for (int i = 0; i < 2; i++) begin
      bad = (i == 0) ? 4'd12 : 4'($urandom_range(12, 15));
      e0 = err_cnt;
      send_cmd(bad);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL bad_idx_err idx=%0d got %b want 1", bad, err); end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || err_cnt !== e0 + 1) begin
        errors++;
        $display("FAIL bad_idx_pulse idx=%0d got err=%b cycles=%0d want 0 1", bad, err, err_cnt - e0);
      end
      checks++;
      if (key_ready !== 1'b1) begin errors++; $display("FAIL bad_idx_ready got %b want 1", key_ready); end
    end
    run_scan(1'b0);
  endtask

  task automatic test_timeout();
    int k, e0;
    bit col_seen;
    k = $urandom_range(0, 8);
    row_i = 4'b0000;
    repeat (3) @(negedge clk);
    send_cmd(4'(k));
    e0 = err_cnt;
    row_i = rtab[k / 3];
    col_seen = 1'b0;
    for (int i = 1; i < T; i++) begin
      @(negedge clk);
      if (col_o !== 3'b000) col_seen = 1'b1;
    end
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got busy=%b err=%b want 1 0", busy, err);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge got err=%b busy=%b ready=%b want 1 0 1", err, busy, key_ready);
    end
    @(negedge clk);
    m_active = 1'b0;
    exp_err++;
    checks++;
    if (err_cnt !== e0 + 1) begin errors++; $display("FAIL timeout_err_cycles got %0d want 1", err_cnt - e0); end
    checks++;
    if (col_seen !== 1'b0) begin errors++; $display("FAIL timeout_col got %b want 0", col_seen); end
  endtask

  task automatic test_back_to_back();
    int a0, d0, c;
    a0 = m_accepts;
    d0 = done_cnt;
    row_i = 4'b0000;
    repeat (3) @(negedge clk);
    key_idx = 4'd0;
    key_valid = 1'b1;
    m_try_accept();
    @(negedge clk);
    key_idx = 4'd1;
    for (int s = 0; s < 3 * (H + G + 1) + 2; s++) begin
      run_scan(1'b0);
      c = m_accepts - a0;
      if (c < 3) key_idx = 4'(c);
      else key_valid = 1'b0;
    end
    key_valid = 1'b0;
    checks++;
    if (done_cnt !== d0 + 3) begin errors++; $display("FAIL b2b_done got %0d want 3", done_cnt - d0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6; c++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_cmd(4'($urandom_range(0, 11)));
      for (int s = 0; s < H + G + 3 && m_active; s++) run_scan(1'($urandom_range(0, 1)));
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL random_cmd%0d_busy got %b want 0", c, busy); end
    end
  endtask

  task automatic test_reset_hold();
    int k, d0;
    k = $urandom_range(0, 8);
    send_cmd(4'(k));
    run_scan(1'b0);
    run_scan(1'b0);
    row_i = rtab[k / 3];
    #1;
    checks++;
    if (col_o !== ctab[k % 3]) begin errors++; $display("FAIL hold_col key=%0d got %b want %b", k, col_o, ctab[k % 3]); end
    rst = 1'b0;
    #1;
    checks++;
    if (col_o !== 3'b000 || key_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold got col=%b ready=%b busy=%b want 000 1 0", col_o, key_ready, busy);
    end
    m_active = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    run_scan(1'b0);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL rst_no_done got %0d want 0", done_cnt - d0); end
  endtask

  initial begin
    rtab[0] = 4'b0100; rtab[1] = 4'b0010; rtab[2] = 4'b0001; rtab[3] = 4'b1000;
    ctab[0] = 3'b100;  ctab[1] = 3'b010;  ctab[2] = 3'b001;
    junk_pat[0] = 4'b0000; junk_pat[1] = 4'b0011; junk_pat[2] = 4'b1100;
    junk_pat[3] = 4'b1111; junk_pat[4] = 4'b0110;
    m_active = 1'b0; m_nstart = 0; m_key = 0; exp_done = 0; exp_err = 0; m_accepts = 0;
    test_reset();
    test_loopback();
    test_star_hash();
    test_bad_idx();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_hold();
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL done_err_overlap got %b want 0", both_seen); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
